square_motion_ctrl: RTL
=======================

# square_motion_ctrl

Per-frame position controller for the on-screen square. It arbitrates between three movement sources (push-buttons, PS/2 keyboard, accelerometer) and advances a small sequencer once per frame on `screen_end`. The sequencer computes a bounded step and clamps the result so the square stays fully on the 640x480 display. Its `center_x`/`center_y` outputs feed the box-drawing logic in the VGA controller, so the square position only changes between frames.

## Interface
- `SCREEN_W`, 640, active width in pixels
- `SCREEN_H`, 480, active height in pixels
- `HALF`, 25, half side of square; clamp margin
- `STEP`, 4, pixels per frame for button/keyboard motion
- `ACCEL_SHIFT`, 5, right-shift applied to accelerometer samples
- `MAX_STEP`, 8, magnitude limit on any per-frame delta

Ports:
- `clk_25mHz`  in  1  pixel clock, single clock domain
- `reset`  in  1  asynchronous, active-low reset
- `screen_end`  in  1  one-cycle pulse between frames
- `BTNU`, `BTNL`, `BTNR`, `BTND`  in  1 each  raw buttons, asynchronous
- `ps2_valid`  in  1  one-cycle strobe, `ps2_code` valid
- `ps2_code`  in  8  received PS/2 set-2 scan byte
- `accel_x`, `accel_y`  in  32  signed two's-complement tilt samples
- `mode`  in  2  source select: 0 buttons, 1 keyboard, 2 accel, 3 auto-priority
- `center_x`  out  10  square centre X
- `center_y`  out  10  square centre Y
- `pos_valid`  out  1  one-cycle pulse on each position commit
- `busy`  out  1  high whenever the FSM is not in IDLE

## Operation
- **Buttons:** each button passes through a 2-flop synchronizer before use.
- **Keyboard tracker:** keeps four held bits for W=0x1D, A=0x1C, S=0x1B, D=0x23.
  - 0xF0 sets `brk_pend`.
  - 0xE0 leaves `brk_pend` unchanged.
  - A tracked code sets its held bit to `!brk_pend`, then clears `brk_pend`.
  - Any other code clears `brk_pend`.
- **Direction delta (buttons/keys):**
  - dx = STEP*(right−left), dy = STEP*(down−up).
  - Opposing inputs cancel to 0.
- **Accel delta:** `accel >>> ACCEL_SHIFT` (arithmetic shift), saturated to ±MAX_STEP.
- **Auto mode:** first non-zero source in priority order buttons > keyboard > accel. If all are zero, delta = 0.
- **FSM states:** IDLE → SAMPLE → APPLY → CLAMP → COMMIT → IDLE.
  - IDLE: waits for `screen_end`.
  - SAMPLE: latches the selected dx/dy as 5-bit signed values.
  - APPLY: computes 11-bit signed sums `center + delta`.
  - CLAMP: limits X to [HALF, SCREEN_W−1−HALF] = [25, 614] and Y to [HALF, SCREEN_H−1−HALF] = [25, 454]. Negative sums clamp to the minimum.
  - COMMIT: registers `center_x`/`center_y` and pulses `pos_valid`.
- `screen_end` arriving outside IDLE is ignored; no queuing.
- `ps2_valid` is processed in every state. Key state is sampled only in SAMPLE.
- A `mode` change takes effect at the next SAMPLE.
- Reset values:
  - `center_x` = 320, `center_y` = 240.
  - `pos_valid` = 0, `busy` = 0, FSM = IDLE.
  - Held bits, `brk_pend` and synchronizers = 0.
- Reset asserted mid-sequence aborts immediately; there is no partial commit.

## Timing
- Let edge E be the edge where IDLE samples `screen_end` = 1.
- SAMPLE occupies E+1, APPLY E+2, CLAMP E+3.
- `center_*` update and `pos_valid` rises at edge E+4. `pos_valid` falls at E+5.
- `busy` is high from E to E+4, i.e. 4 cycles.
- Button-to-effect latency: 2 synchronizer cycles plus waiting for the next `screen_end`.
- A `ps2_valid` strobe is reflected in the held bits on the following edge. A key event on the same edge as SAMPLE is seen next frame.
- Maximum movement is one delta per frame.

## Structure
- Shared package `square_game_pkg`:
  - FSM state enum
  - scan-code constants (0xF0, 0xE0, W/A/S/D)
  - default centre constants (320, 240)
  - `mode` encodings
- Sub-module `ps2_key_tracker`: make/break decoding, exporting a 4-bit held vector.
- Everything else stays in `square_motion_ctrl`.

## Test plan
- **Reset and idle:** release reset, no inputs, 3 `screen_end` pulses → centre stays (320,240); `pos_valid` pulses 3 times, each 4 cycles after `screen_end`.
- **Buttons at wall:** `mode`=0, BTNR held, 80 frames → `center_x` rises by 4 per frame, then saturates at 614. BTNL+BTNR together → no change.
- **Keyboard make/break:** `mode`=1, send 0x1D → `center_y` decrements by 4 per frame. Send 0xF0, 0x1D → motion stops. Send 0xE0, 0xF0, 0x1C with A not held → no change.
- **Accel saturation:** `mode`=2, `accel_x`=−1000, `accel_y`=64 → dx = −8 (saturated), dy = +2 per frame. From X=30 → 25 after one frame, then holds at 25.
- **Auto priority:** `mode`=3, BTND held, key D held, `accel_x`=256 → only dy = +4 applies. Release BTND → dx = +4 from keyboard.
- **Mid-sequence events:** `screen_end` at E+2 → ignored, single commit. Reset asserted at E+3 → outputs return to (320,240) with no `pos_valid`.

Source files
------------

// File: rtl/square_game_pkg.sv
// square_game_pkg: shared types and constants for the square game.
// Holds the motion FSM states, PS/2 scan codes, reset centre and mode codes.
package square_game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_APPLY,
    ST_CLAMP,
    ST_COMMIT
  } state_t;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;

  // bit positions in the held-key vector
  localparam int KEY_W = 0;
  localparam int KEY_A = 1;
  localparam int KEY_S = 2;
  localparam int KEY_D = 3;

  localparam logic [9:0] CENTER_X0 = 10'd320;
  localparam logic [9:0] CENTER_Y0 = 10'd240;

  localparam logic [1:0] MODE_BTN   = 2'd0;
  localparam logic [1:0] MODE_KEY   = 2'd1;
  localparam logic [1:0] MODE_ACCEL = 2'd2;
  localparam logic [1:0] MODE_AUTO  = 2'd3;

endpackage

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: PS/2 set-2 make/break decoder for the W/A/S/D keys.
// Ports: clk, rst_n (async low), i_valid/i_code byte strobe, o_held {D,S,A,W}.
module ps2_key_tracker
  import square_game_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_valid,
  input  logic [7:0] i_code,
  output logic [3:0] o_held
);

  logic       r_brk;
  logic [3:0] r_held;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_brk  <= 1'b0;
      r_held <= '0;
    end else if (i_valid) begin
      unique case (i_code)
        SC_BREAK: r_brk <= 1'b1;
        // extended prefix must not cancel a pending break
        SC_EXT:   r_brk <= r_brk;
        SC_W: begin
          r_held[KEY_W] <= !r_brk;
          r_brk         <= 1'b0;
        end
        SC_A: begin
          r_held[KEY_A] <= !r_brk;
          r_brk         <= 1'b0;
        end
        SC_S: begin
          r_held[KEY_S] <= !r_brk;
          r_brk         <= 1'b0;
        end
        SC_D: begin
          r_held[KEY_D] <= !r_brk;
          r_brk         <= 1'b0;
        end
        default: r_brk <= 1'b0;
      endcase
    end
  end

  assign o_held = r_held;

endmodule

// File: rtl/square_motion_ctrl.sv
// square_motion_ctrl: per-frame square position sequencer and source arbiter.
// In: clk_25mHz, reset (async low), screen_end, BTNU/L/R/D, ps2_valid/ps2_code,
//     accel_x/y, mode. Out: center_x/y, pos_valid pulse, busy.
module square_motion_ctrl
  import square_game_pkg::*;
#(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int HALF        = 25,
  parameter int STEP        = 4,
  parameter int ACCEL_SHIFT = 5,
  parameter int MAX_STEP    = 8
) (
  input  logic               clk_25mHz,
  input  logic               reset,
  input  logic               screen_end,
  input  logic               BTNU,
  input  logic               BTNL,
  input  logic               BTNR,
  input  logic               BTND,
  input  logic               ps2_valid,
  input  logic [7:0]         ps2_code,
  input  logic signed [31:0] accel_x,
  input  logic signed [31:0] accel_y,
  input  logic [1:0]         mode,
  output logic [9:0]         center_x,
  output logic [9:0]         center_y,
  output logic               pos_valid,
  output logic               busy
);

  localparam logic signed [4:0]  STEP_D = 5'(STEP);
  localparam logic signed [31:0] MAX_S  = 32'(MAX_STEP);
  localparam logic signed [10:0] X_MIN  = 11'(HALF);
  localparam logic signed [10:0] X_MAX  = 11'(SCREEN_W - 1 - HALF);
  localparam logic signed [10:0] Y_MIN  = 11'(HALF);
  localparam logic signed [10:0] Y_MAX  = 11'(SCREEN_H - 1 - HALF);

  function automatic logic signed [4:0] dir_delta(
    input logic p,
    input logic n
  );
    logic signed [4:0] d;
    d = '0;
    if (p && !n) d = STEP_D;
    else if (n && !p) d = -STEP_D;
    return d;
  endfunction

  function automatic logic signed [4:0] sat_accel(
    input logic signed [31:0] a
  );
    logic signed [31:0] s;
    s = a >>> ACCEL_SHIFT;
    if (s > MAX_S) s = MAX_S;
    else if (s < -MAX_S) s = -MAX_S;
    return s[4:0];
  endfunction

  function automatic logic [9:0] clamp(
    input logic signed [10:0] v,
    input logic signed [10:0] lo,
    input logic signed [10:0] hi
  );
    logic signed [10:0] r;
    if (v < lo) r = lo;
    else if (v > hi) r = hi;
    else r = v;
    return r[9:0];
  endfunction

  state_t r_state, w_next;

  logic [3:0]        r_sync1, r_sync2;
  logic [3:0]        w_held;
  logic signed [4:0] w_btn_dx, w_btn_dy;
  logic signed [4:0] w_key_dx, w_key_dy;
  logic signed [4:0] w_acc_dx, w_acc_dy;
  logic signed [4:0] w_sel_dx, w_sel_dy;
  logic signed [4:0] r_dx, r_dy;
  logic signed [10:0] w_sum_x, w_sum_y;
  logic signed [10:0] r_sum_x, r_sum_y;
  logic [9:0]        r_clp_x, r_clp_y;
  logic [9:0]        r_cx, r_cy;
  logic              r_pos_valid;

  // r_sync*: {D, R, L, U}
  always_ff @(posedge clk_25mHz or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {BTND, BTNR, BTNL, BTNU};
      r_sync2 <= r_sync1;
    end
  end

  ps2_key_tracker u_keys (
    .clk     (clk_25mHz),
    .rst_n   (reset),
    .i_valid (ps2_valid),
    .i_code  (ps2_code),
    .o_held  (w_held)
  );

  assign w_btn_dx = dir_delta(r_sync2[2], r_sync2[1]);
  assign w_btn_dy = dir_delta(r_sync2[3], r_sync2[0]);
  assign w_key_dx = dir_delta(w_held[KEY_D], w_held[KEY_A]);
  assign w_key_dy = dir_delta(w_held[KEY_S], w_held[KEY_W]);
  assign w_acc_dx = sat_accel(accel_x);
  assign w_acc_dy = sat_accel(accel_y);

  // auto mode takes a whole (dx,dy) pair from the first active source
  always_comb begin
    w_sel_dx = '0;
    w_sel_dy = '0;
    unique case (mode)
      MODE_BTN: begin
        w_sel_dx = w_btn_dx;
        w_sel_dy = w_btn_dy;
      end
      MODE_KEY: begin
        w_sel_dx = w_key_dx;
        w_sel_dy = w_key_dy;
      end
      MODE_ACCEL: begin
        w_sel_dx = w_acc_dx;
        w_sel_dy = w_acc_dy;
      end
      MODE_AUTO: begin
        if (w_btn_dx != '0 || w_btn_dy != '0) begin
          w_sel_dx = w_btn_dx;
          w_sel_dy = w_btn_dy;
        end else if (w_key_dx != '0 || w_key_dy != '0) begin
          w_sel_dx = w_key_dx;
          w_sel_dy = w_key_dy;
        end else begin
          w_sel_dx = w_acc_dx;
          w_sel_dy = w_acc_dy;
        end
      end
    endcase
  end

  always_ff @(posedge clk_25mHz or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (screen_end) w_next = ST_SAMPLE;
      ST_SAMPLE: w_next = ST_APPLY;
      ST_APPLY:  w_next = ST_CLAMP;
      ST_CLAMP:  w_next = ST_COMMIT;
      ST_COMMIT: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  assign w_sum_x = 11'({1'b0, r_cx}) + {{6{r_dx[4]}}, r_dx};
  assign w_sum_y = 11'({1'b0, r_cy}) + {{6{r_dy[4]}}, r_dy};

  always_ff @(posedge clk_25mHz or negedge reset) begin
    if (!reset) begin
      r_dx        <= '0;
      r_dy        <= '0;
      r_sum_x     <= '0;
      r_sum_y     <= '0;
      r_clp_x     <= CENTER_X0;
      r_clp_y     <= CENTER_Y0;
      r_cx        <= CENTER_X0;
      r_cy        <= CENTER_Y0;
      r_pos_valid <= 1'b0;
    end else begin
      r_pos_valid <= 1'b0;
      unique case (r_state)
        ST_SAMPLE: begin
          r_dx <= w_sel_dx;
          r_dy <= w_sel_dy;
        end
        ST_APPLY: begin
          r_sum_x <= w_sum_x;
          r_sum_y <= w_sum_y;
        end
        ST_CLAMP: begin
          r_clp_x <= clamp(r_sum_x, X_MIN, X_MAX);
          r_clp_y <= clamp(r_sum_y, Y_MIN, Y_MAX);
        end
        ST_COMMIT: begin
          r_cx        <= r_clp_x;
          r_cy        <= r_clp_y;
          r_pos_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign center_x  = r_cx;
  assign center_y  = r_cy;
  assign pos_valid = r_pos_valid;
  assign busy      = (r_state != ST_IDLE);

endmodule
